// File: rtl/operand_pkg.sv
// Shared definitions for the operand collector: source-select codes and
// the occupancy-counter width helper.
package operand_pkg;

  localparam int SRC_RS  = 0;
  localparam int SRC_BUS = 1;
  localparam int SRC_PC  = 2;
  localparam int SRC_IMM = 3;

  // Occupancy runs 0..DEPTH inclusive, so one bit more than the pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// One operand channel: DEPTH-entry FIFO with registered storage and a
// head output that reads zero while empty.
module operand_fifo
  import operand_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_w(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign overflow_o = push_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/operand_collect_regs.sv
// Operand collector: per-channel source mux into a FIFO, joined valid/ready
// output, sticky channels that keep their head, and a sticky overflow flag.
module operand_collect_regs
  import operand_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NUM_CH  = 2,
  parameter  int NUM_SRC = 4,
  parameter  int DEPTH   = 2,
  localparam int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH*NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_CH*SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]               en,
  input  logic [NUM_CH-1:0]               sticky,
  input  logic                            flush,
  output logic [NUM_CH-1:0]               full,
  output logic [NUM_CH*CW-1:0]            count,
  output logic [NUM_CH*WIDTH-1:0]         out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            overflow
);

  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] ovf_pulse;
  logic [NUM_CH-1:0] pop;
  logic              fire;
  logic              overflow_q;

  assign out_valid = ~|empty;
  assign fire      = out_valid & out_ready;
  assign pop       = {NUM_CH{fire}} & ~sticky;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] wdata;

    // Out-of-range selects fall through to zero.
    always_comb begin
      wdata = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        if (sel[c*SEL_W +: SEL_W] == SEL_W'(s))
          wdata = src_data[(c*NUM_SRC+s)*WIDTH +: WIDTH];
      end
    end

    operand_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (reset),
      .push_i     (en[c]),
      .pop_i      (pop[c]),
      .flush_i    (flush),
      .wdata_i    (wdata),
      .head_o     (out_data[c*WIDTH +: WIDTH]),
      .count_o    (count[c*CW +: CW]),
      .full_o     (full[c]),
      .empty_o    (empty[c]),
      .overflow_o (ovf_pulse[c])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              overflow_q <= 1'b0;
    else if (flush)          overflow_q <= 1'b0;
    else if (|ovf_pulse)     overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

endmodule
